// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: mode codes and FSM state encoding shared by the key controller and the LED selector
//   MODE_W   width of the mode code
//   MODE_OFF code for "LEDs dark"
//   state_t  OFF/RUN encoding (ST_OFF, ST_RUN)
package led_ctrl_pkg;
  localparam int MODE_W = 4;
  localparam logic [MODE_W-1:0] MODE_OFF = 4'd0;
  typedef enum logic {ST_OFF = 1'b0, ST_RUN = 1'b1} state_t;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer, debounce counter and press detector for one active-low key
//   clk    in  system clock
//   rst_n  in  asynchronous reset, active low
//   key_n  in  raw key pin, low = pressed
//   press  out one-cycle pulse on an accepted 1->0 transition
module key_debounce #(
  parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  logic s1, s2, level, accept;
  logic [19:0] cnt;
  // The synced level must disagree with the accepted level for DEB_CYCLES consecutive cycles.
  assign accept = (s2 != level) && (cnt == DEB_CYCLES - 20'd1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      cnt   <= (s2 == level || accept) ? '0 : cnt + 20'd1;
      level <= accept ? s2 : level;
      press <= accept && !s2;
    end
  end
endmodule

// File: rtl/mode_key_controller.sv
// mode_key_controller: debounced three-key front end driving the OFF/RUN mode FSM for the LED selector
//   clk          in  system clock
//   rst_n        in  asynchronous reset, active low
//   key_next_n   in  raw key, low = pressed; next mode
//   key_prev_n   in  raw key, low = pressed; previous mode
//   key_off_n    in  raw key, low = pressed; toggle OFF/RUN
//   mode_select  out registered mode code, 0 = off, 1..NUM_MODES = pattern
//   mode_changed out one-cycle pulse coincident with a new mode_select value
// Optional feature: define AUTO_CYCLE_EN to auto-advance the mode every AUTO_PERIOD cycles in RUN.
module mode_key_controller
  import led_ctrl_pkg::*;
#(
  parameter logic [19:0] DEB_CYCLES  = 20'd500000,
  parameter int          NUM_MODES   = 4,
  parameter logic [31:0] AUTO_PERIOD = 32'd100000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_next_n,
  input  logic              key_prev_n,
  input  logic              key_off_n,
  output logic [MODE_W-1:0] mode_select,
  output logic              mode_changed
);
  localparam logic [MODE_W-1:0] TOP = MODE_W'(NUM_MODES);
  logic p_next, p_prev, p_off, any, fwd, bwd, tick;
  state_t state, state_n;
  logic [MODE_W-1:0] last, last_n, mode_n, inc, dec;
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_next (.clk(clk), .rst_n(rst_n), .key_n(key_next_n), .press(p_next));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_prev (.clk(clk), .rst_n(rst_n), .key_n(key_prev_n), .press(p_prev));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_off  (.clk(clk), .rst_n(rst_n), .key_n(key_off_n),  .press(p_off));
  assign any = p_next || p_prev || p_off;
  // next and prev in the same cycle cancel each other
  assign fwd = p_next && !p_prev;
  assign bwd = p_prev && !p_next;
  assign inc = (last == TOP) ? 4'd1 : last + 4'd1;
  assign dec = (last == 4'd1) ? TOP : last - 4'd1;
`ifdef AUTO_CYCLE_EN
  logic [31:0] timer;
  // any key press in the expiry cycle takes precedence over the timer
  assign tick = (state == ST_RUN) && (timer == AUTO_PERIOD - 32'd1) && !any;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer <= '0;
    else timer <= (state != ST_RUN || state_n != ST_RUN || any || tick) ? '0 : timer + 32'd1;
  end
`else
  assign tick = 1'b0;
`endif
  always_comb begin
    state_n = state;
    last_n  = last;
    if (p_off) begin
      state_n = (state == ST_OFF) ? ST_RUN : ST_OFF;
    end else if (state == ST_OFF) begin
      state_n = (fwd || bwd) ? ST_RUN : ST_OFF;
      last_n  = bwd ? dec : last;
    end else begin
      last_n = (fwd || tick) ? inc : bwd ? dec : last;
    end
    mode_n = (state_n == ST_RUN) ? last_n : MODE_OFF;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_OFF;
      last         <= 4'd1;
      mode_select  <= MODE_OFF;
      mode_changed <= 1'b0;
    end else begin
      state        <= state_n;
      last         <= last_n;
      mode_select  <= mode_n;
      mode_changed <= mode_n != mode_select;
    end
  end
endmodule

// File: tb/tb_mode_key_controller.sv
// tb_mode_key_controller: directed self-checking bench for mode_key_controller (DEB_CYCLES=4, NUM_MODES=4, AUTO_PERIOD=50)
module tb_mode_key_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_next_n = 1'b1;
  logic key_prev_n = 1'b1;
  logic key_off_n = 1'b1;
  logic [3:0] mode_select;
  logic mode_changed;
  int checks = 0;
  int failures = 0;
  int pulses = 0;
  mode_key_controller #(.DEB_CYCLES(20'd4), .NUM_MODES(4), .AUTO_PERIOD(32'd50)) dut (
    .clk(clk), .rst_n(rst_n), .key_next_n(key_next_n), .key_prev_n(key_prev_n),
    .key_off_n(key_off_n), .mode_select(mode_select), .mode_changed(mode_changed)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mode_changed) pulses <= pulses + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // press the keys in mask {next,prev,off} for 10 cycles, release and let everything settle
  task automatic tap(input logic [2:0] m);
    {key_next_n, key_prev_n, key_off_n} = ~m;
    repeat (10) @(negedge clk);
    {key_next_n, key_prev_n, key_off_n} = 3'b111;
    repeat (12) @(negedge clk);
  endtask
  initial begin
    logic [3:0] seq [5];
    seq = '{4'd2, 4'd3, 4'd4, 4'd1, 4'd2};
    repeat (3) @(negedge clk);
    check("reset_mode", mode_select, 0);
    check("reset_chg", mode_changed, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_mode", mode_select, 0);
    check("idle_pulses", pulses, 0);
`ifdef AUTO_CYCLE_EN
    key_next_n = 1'b0;
    repeat (7) @(negedge clk);
    check("auto_start", mode_select, 1);
    repeat (3) @(negedge clk);
    key_next_n = 1'b1;
    repeat (46) @(negedge clk);
    check("auto_hold1", mode_select, 1);
    @(negedge clk);
    check("auto_adv1", mode_select, 2);
    check("auto_chg1", mode_changed, 1);
    repeat (33) @(negedge clk);
    key_next_n = 1'b0;
    repeat (7) @(negedge clk);
    check("auto_press", mode_select, 3);
    repeat (3) @(negedge clk);
    key_next_n = 1'b1;
    repeat (46) @(negedge clk);
    check("auto_restart_hold", mode_select, 3);
    @(negedge clk);
    check("auto_restart_adv", mode_select, 4);
    repeat (50) @(negedge clk);
    check("auto_wrap", mode_select, 1);
`else
    key_next_n = 1'b0;
    repeat (6) @(negedge clk);
    check("lat_before", mode_select, 0);
    @(negedge clk);
    check("lat_mode", mode_select, 1);
    check("lat_chg", mode_changed, 1);
    @(negedge clk);
    check("lat_chg_clear", mode_changed, 0);
    repeat (2) @(negedge clk);
    key_next_n = 1'b1;
    repeat (12) @(negedge clk);
    check("first_pulses", pulses, 1);
    for (int i = 0; i < 5; i++) begin
      tap(3'b100);
      check($sformatf("next_%0d", i), mode_select, seq[i]);
    end
    tap(3'b010);
    check("prev_to1", mode_select, 1);
    tap(3'b010);
    check("prev_wrap", mode_select, 4);
    check("seq_pulses", pulses, 8);
    for (int i = 0; i < 5; i++) begin
      key_next_n = 1'b0;
      repeat (3) @(negedge clk);
      key_next_n = 1'b1;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    check("glitch_mode", mode_select, 4);
    check("glitch_pulses", pulses, 8);
    tap(3'b010);
    check("to3", mode_select, 3);
    tap(3'b001);
    check("off", mode_select, 0);
    tap(3'b001);
    check("resume", mode_select, 3);
    tap(3'b101);
    check("off_wins_run", mode_select, 0);
    tap(3'b101);
    check("off_wins_off", mode_select, 3);
    tap(3'b110);
    check("next_prev_mode", mode_select, 3);
    check("next_prev_pulses", pulses, 13);
    tap(3'b001);
    tap(3'b010);
    check("prev_from_off", mode_select, 2);
    check("total_pulses", pulses, 15);
    key_next_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_mode", mode_select, 0);
    check("async_chg", mode_changed, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("held_before", mode_select, 0);
    @(negedge clk);
    check("held_mode", mode_select, 1);
    check("held_chg", mode_changed, 1);
    key_next_n = 1'b1;
    repeat (12) @(negedge clk);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
